// File: rtl/one_wire_slave.sv
// 1-Wire responder PHY: reset/presence, write-slot decode, read-slot answer.
// Optional OW_GLITCH_FILTER_EN adds a 3-sample majority filter on the bus.
module one_wire_slave #(
  parameter int CLKS_PER_US  = 50,
  parameter int RST_MIN_US   = 400,
  parameter int PRES_WAIT_US = 30,
  parameter int PRES_LEN_US  = 120,
  parameter int SAMPLE_US    = 30,
  parameter int RD0_HOLD_US  = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ow_i,
  output logic       ow_drive_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_load_i,
  output logic       tx_ready_o,
  output logic       bus_reset_o,
  output logic       busy_o
);

  localparam int RST_CYC = RST_MIN_US * CLKS_PER_US;
  localparam int TW      = $clog2(RST_CYC + 1);

  localparam logic [TW-1:0] T_SAT = TW'(RST_CYC);
  localparam logic [TW-1:0] T_RST = TW'(RST_CYC - 1);
  localparam logic [TW-1:0] T_PW  = TW'(PRES_WAIT_US * CLKS_PER_US - 1);
  localparam logic [TW-1:0] T_PL  = TW'(PRES_LEN_US * CLKS_PER_US - 1);
  localparam logic [TW-1:0] T_SMP = TW'(SAMPLE_US * CLKS_PER_US - 1);
  localparam logic [TW-1:0] T_RD0 = TW'(RD0_HOLD_US * CLKS_PER_US - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SLOT,
    S_RECOVER,
    S_RST_LOW,
    S_PRES_WAIT,
    S_PRES_DRIVE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_sync;
  logic            r_prev;
  logic [TW-1:0]   r_tmr;
  logic            r_drive;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_rx_sh;
  logic [7:0]      r_rx_data;
  logic            r_rx_valid;
  logic [7:0]      r_tx_sh;
  logic            r_tx_pend;
  logic            r_tx_mode;
  logic            r_bus_rst;

  logic            w_line;
  logic            w_fall;
  logic            w_rise;
  logic            w_rst_det;
  logic            w_tmr_clr;
  logic            w_drive_nxt;
  logic            w_sample;
  logic            w_bit_done;
  logic            w_bus_rst;
  logic            w_tx_now;
  logic            w_tx_bit;
  logic            w_pres;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], ow_i};
    end
  end

`ifdef OW_GLITCH_FILTER_EN
  logic [1:0] r_hist;
  logic       r_filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= 2'b11;
      r_filt <= 1'b1;
    end else begin
      r_hist <= {r_hist[0], r_sync[1]};
      r_filt <= (r_sync[1] & r_hist[0]) |
                (r_sync[1] & r_hist[1]) |
                (r_hist[0] & r_hist[1]);
    end
  end

  assign w_line = r_filt;
`else
  assign w_line = r_sync[1];
`endif

  assign w_fall   = r_prev & ~w_line;
  assign w_rise   = ~r_prev & w_line;
  assign w_pres   = (r_state == S_PRES_WAIT) ||
                    (r_state == S_PRES_DRIVE);
  assign w_tx_now = (r_bitcnt == 3'd0) ? r_tx_pend : r_tx_mode;
  assign w_tx_bit = r_tx_sh[r_bitcnt];

  // Own drive pulls the line low, so it must never look like a master reset.
  assign w_rst_det = (r_state != S_RST_LOW) && !r_drive &&
                     !w_line && !w_fall && (r_tmr >= T_RST);

  always_comb begin
    w_state_nxt = r_state;
    w_drive_nxt = r_drive;
    w_tmr_clr   = w_fall && !r_drive && !w_pres;
    w_sample    = 1'b0;
    w_bit_done  = 1'b0;
    w_bus_rst   = 1'b0;
    if (w_rst_det) begin
      w_state_nxt = S_RST_LOW;
      w_drive_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            w_state_nxt = S_SLOT;
            w_drive_nxt = w_tx_now & ~w_tx_bit;
          end
        end
        S_SLOT: begin
          if (r_tx_mode ? (r_tmr >= T_RD0) : (r_tmr >= T_SMP)) begin
            w_state_nxt = S_RECOVER;
            w_drive_nxt = 1'b0;
            w_sample    = ~r_tx_mode;
          end
        end
        S_RECOVER: begin
          if (w_line) begin
            w_state_nxt = S_IDLE;
            w_bit_done  = 1'b1;
          end
        end
        S_RST_LOW: begin
          w_drive_nxt = 1'b0;
          if (w_rise) begin
            w_state_nxt = S_PRES_WAIT;
            w_bus_rst   = 1'b1;
            w_tmr_clr   = 1'b1;
          end
        end
        S_PRES_WAIT: begin
          if (r_tmr >= T_PW) begin
            w_state_nxt = S_PRES_DRIVE;
            w_drive_nxt = 1'b1;
            w_tmr_clr   = 1'b1;
          end
        end
        S_PRES_DRIVE: begin
          if (r_tmr >= T_PL) begin
            w_state_nxt = S_IDLE;
            w_drive_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_drive_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev     <= 1'b1;
      r_tmr      <= '0;
      r_drive    <= 1'b0;
      r_bitcnt   <= 3'd0;
      r_rx_sh    <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_sh    <= 8'h00;
      r_tx_pend  <= 1'b0;
      r_tx_mode  <= 1'b0;
      r_bus_rst  <= 1'b0;
    end else begin
      r_prev     <= w_line;
      r_drive    <= w_drive_nxt;
      r_bus_rst  <= w_bus_rst;
      r_rx_valid <= 1'b0;
      if (w_tmr_clr) begin
        r_tmr <= '0;
      end else if (r_tmr != T_SAT) begin
        r_tmr <= r_tmr + 1'b1;
      end
      if (w_rst_det) begin
        r_bitcnt  <= 3'd0;
        r_rx_sh   <= 8'h00;
        r_tx_pend <= 1'b0;
      end else begin
        if (tx_load_i && !r_tx_pend) begin
          r_tx_sh   <= tx_data_i;
          r_tx_pend <= 1'b1;
        end
        // Byte direction is frozen at the first slot of each byte.
        if (r_state == S_IDLE && w_fall && r_bitcnt == 3'd0) begin
          r_tx_mode <= r_tx_pend;
        end
        if (w_sample) begin
          r_rx_sh[r_bitcnt] <= w_line;
        end
        if (w_bit_done) begin
          r_bitcnt <= r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            if (r_tx_mode) begin
              r_tx_pend <= 1'b0;
            end else begin
              r_rx_data  <= r_rx_sh;
              r_rx_valid <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign ow_drive_o  = r_drive;
  assign rx_data_o   = r_rx_data;
  assign rx_valid_o  = r_rx_valid;
  assign tx_ready_o  = ~r_tx_pend;
  assign bus_reset_o = r_bus_rst;
  assign busy_o      = (r_state != S_IDLE);

endmodule

// File: doc/one_wire_slave.md
Name: one_wire_slave

Overview:
- 1-Wire responder (slave) PHY: the bus-side counterpart of the team's 1-Wire master.
- Detects master reset pulses and answers with a presence pulse.
- Decodes write slots into received bytes and serves read slots from a loaded transmit byte, LSB first.
- Sits behind an open-drain pad; ROM/function-command logic lives above it.

Parameters:
- CLKS_PER_US, 50, clock cycles per microsecond (all timings derived from it)
- RST_MIN_US, 400, minimum low time classified as bus reset
- PRES_WAIT_US, 30, delay from reset rising edge to presence start
- PRES_LEN_US, 120, presence pulse length
- SAMPLE_US, 30, write-slot sample point after falling edge
- RD0_HOLD_US, 30, low-hold time when answering a read slot with 0

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ow_i  input  1  raw bus level from pad (asynchronous)
- ow_drive_o  output  1  1 = pull bus low (pad OE), 0 = release
- rx_data_o  output  8  last received byte
- rx_valid_o  output  1  one-cycle pulse, rx_data_o valid
- tx_data_i  input  8  byte to return on the next 8 read slots
- tx_load_i  input  1  load strobe, accepted only when tx_ready_o=1
- tx_ready_o  output  1  no transmit byte pending
- bus_reset_o  output  1  one-cycle pulse on completed bus reset
- busy_o  output  1  state != IDLE

Behaviour:
- Reset is asynchronous and active-low. Reset values: ow_drive_o=0, rx_data_o=0, rx_valid_o=0, tx_ready_o=1, bus_reset_o=0, busy_o=0.
- ow_i passes a 2-FF synchronizer. Falling and rising edges are detected on the synchronized level. All timings are counted from the detected edge.
- Single timer sized to clog2(RST_MIN_US*CLKS_PER_US+1) bits.
  - Restarts on every falling edge.
  - Saturates; never wraps.
- States:
  - IDLE: waits for a falling edge, then enters SLOT.
  - SLOT:
    - Byte mode is fixed at bit 0: TX if a byte is pending, else RX.
    - RX: sample the line at SAMPLE_US and shift it into bit[bitcnt].
    - TX, current bit 0: assert ow_drive_o immediately on edge detection (cycle after the detected edge), release at RD0_HOLD_US.
    - TX, current bit 1: never drive.
    - Then go to RECOVER.
  - RECOVER: waits for the line high, bitcnt++, returns to IDLE.
  - RST_LOW: entered from any state when the line is low for RST_MIN_US.
    - Forces ow_drive_o=0.
    - Clears bitcnt and discards the partial byte.
    - Discards any pending TX byte (tx_ready_o=1).
    - On the rising edge: pulse bus_reset_o, go to PRES_WAIT.
  - PRES_WAIT: waits PRES_WAIT_US, then PRES_DRIVE.
  - PRES_DRIVE: ow_drive_o=1 for PRES_LEN_US, then IDLE.
- Falling edges in PRES_WAIT or PRES_DRIVE are ignored. A low lasting RST_MIN_US still restarts the reset sequence.
- Byte completion (bitcnt 7 to 0):
  - RX: rx_data_o updates and rx_valid_o pulses in the same cycle.
  - TX: tx_ready_o returns to 1.
- tx_load_i:
  - Latched when tx_ready_o=1; tx_ready_o drops the next cycle.
  - Ignored when tx_ready_o=0.
  - A load mid-RX-byte stays pending and takes effect at the next byte boundary.
- The slave's own drive never counts toward reset detection: the timer is not evaluated while ow_drive_o=1.

Optional Feature:
- OW_GLITCH_FILTER_EN defined: a 3-sample majority filter follows the synchronizer.
  - Edge latency grows by 2 cycles.
  - Any single-cycle pulse on ow_i is rejected.
- Undefined: no filter; 2-cycle synchronizer latency only.

Test Plan:
All scenarios use CLKS_PER_US=10.
- Master holds ow_i low 480 us, releases -> bus_reset_o pulses once; ow_drive_o=1 from 30 us to 150 us after release; state ends in IDLE.
- After reset, master writes 0xA5 LSB first (write-1: 6 us low; write-0: 60 us low; 70 us slots) -> rx_valid_o single pulse, rx_data_o=0xA5.
- tx_data_i=0x3C loaded, 8 read slots (2 us low initiator) -> ow_drive_o held 30 us exactly on slots 0,1,6,7; tx_ready_o=1 after slot 7.
- Reset pulse after 3 bits of an RX byte -> no rx_valid_o; the next full byte 0x81 is received correctly.
- tx_load_i with 0x55 issued during an RX byte, then a second load with 0xFF while tx_ready_o=0 -> RX byte completes; the next byte transmits 0x55; 0xFF is ignored.
- With OW_GLITCH_FILTER_EN: a 1-cycle low glitch on ow_i in IDLE -> no slot is started and rx/tx state is unchanged.
